// File: rtl/gpio_pattern_sched_pkg.sv
// rtl/gpio_pattern_sched_pkg.sv - shared constants and state type for the LED pattern sequencer
package gpio_pattern_sched_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_PW    = 27;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } state_e;

endpackage

// File: rtl/gpio_pattern_sched_if.sv
// rtl/gpio_pattern_sched_if.sv - config/control/LED bundle between CSR glue and the pattern sequencer
interface gpio_pattern_sched_if
    import gpio_pattern_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = DEF_PW
);
    localparam int AW = $clog2(DEPTH);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_data;
    logic [AW:0]      len;
    logic [PW-1:0]    period;
    logic             loop;
    logic             start;
    logic             stop;

    logic [WIDTH-1:0] led_out;
    logic             step_tick;
    logic [AW-1:0]    step_idx;
    logic             busy;
    logic             done;

    modport master (
        output cfg_we, cfg_addr, cfg_data, len, period, loop, start, stop,
        input  led_out, step_tick, step_idx, busy, done
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, len, period, loop, start, stop,
        output led_out, step_tick, step_idx, busy, done
    );

endinterface

// File: rtl/gpio_step_timer.sv
// rtl/gpio_step_timer.sv - step-period counter with clear and terminal count at count == period
module gpio_step_timer
    import gpio_pattern_sched_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [PW-1:0] period_i,
    output logic          tc_o
);
    logic [PW-1:0] cnt_q, cnt_d;

    // Terminal count compares for equality, so period = all-ones never overflows.
    assign tc_o = (cnt_q == period_i);

    // Next count: clear wins, then wrap to zero at terminal count, else count up.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + PW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gpio_pattern_sched.sv
// rtl/gpio_pattern_sched.sv - programmable LED pattern sequencer driving the GPIO LED bank
module gpio_pattern_sched
    import gpio_pattern_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PW    = DEF_PW
) (
    input logic clk,
    input logic rst,
    gpio_pattern_sched_if.slave bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] IDX0  = '0;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pat_q [DEPTH];
    logic [WIDTH-1:0] led_q, led_d;
    logic [AW-1:0]    idx_q, idx_d, idx_nxt;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic [AW:0]      len_q, len_d, len_lat;
    logic [PW-1:0]    period_q, period_d;
    logic             loop_q, loop_d;
    logic             tmr_clr, tmr_en, tmr_tc;
    logic             has_next;

    assign idx_nxt  = idx_q + AW'(1);
    assign has_next = (({1'b0, idx_q} + (AW+1)'(1)) < len_q);
    // Requested lengths beyond the table play the whole table once.
    assign len_lat  = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;

    gpio_step_timer #(.PW(PW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .period_i (period_q),
        .tc_o     (tmr_tc)
    );

    // Pattern table: cleared by reset, writable in any state; loads see the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pat_q[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            pat_q[bus.cfg_addr] <= bus.cfg_data;
        end
    end

    // Sequencer next state: start/stop handling and entry stepping on timer terminal count.
    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        idx_d    = idx_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        len_d    = len_q;
        period_d = period_q;
        loop_d   = loop_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    len_d    = len_lat;
                    period_d = bus.period;
                    loop_d   = bus.loop;
                    tmr_clr  = 1'b1;
                    if (len_lat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        led_d   = pat_q[IDX0];
                        idx_d   = IDX0;
                        tick_d  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    tmr_clr = 1'b1;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_tc) begin
                        if (has_next) begin
                            idx_d  = idx_nxt;
                            led_d  = pat_q[idx_nxt];
                            tick_d = 1'b1;
                        end else if (loop_q) begin
                            idx_d  = IDX0;
                            led_d  = pat_q[IDX0];
                            tick_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            led_q    <= '0;
            idx_q    <= '0;
            tick_q   <= 1'b0;
            done_q   <= 1'b0;
            len_q    <= '0;
            period_q <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            idx_q    <= idx_d;
            tick_q   <= tick_d;
            done_q   <= done_d;
            len_q    <= len_d;
            period_q <= period_d;
            loop_q   <= loop_d;
        end
    end

    assign bus.led_out   = led_q;
    assign bus.step_tick = tick_q;
    assign bus.step_idx  = idx_q;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = done_q;

endmodule

// File: doc/gpio_pattern_sched.md
# gpio_pattern_sched

Sequencer that drives the GPIO LED bank from a small programmable pattern table instead of a static CPU value. Software writes up to DEPTH pattern words, sets a step length and count, then pulses `start`; the block steps through the table at the programmed rate, optionally looping, and reports completion. It sits between the CSR bus glue and the LED pins, replacing the direct `valor_led`→LED path when pattern mode is used.

## Interface

- `WIDTH`, 8, LED bank width
- `DEPTH`, 8, pattern table entries (power of two); `AW` = log2(DEPTH), derived
- `PW`, 27, width of the step-period counter

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cfg_we`  in  1  pattern table write strobe
- `cfg_addr`  in  AW  table write address
- `cfg_data`  in  WIDTH  table write data
- `len`  in  AW+1  steps per pass; sampled on accepted `start`
- `period`  in  PW  step duration minus one, in clk cycles; sampled on accepted `start`
- `loop`  in  1  1 = restart at entry 0 after last step; sampled on accepted `start`
- `start`  in  1  begin sequence (level sampled each edge)
- `stop`  in  1  abort sequence
- `led_out`  out  WIDTH  LED drive
- `step_tick`  out  1  one-cycle pulse each time `led_out` loads a table entry
- `step_idx`  out  AW  index of entry currently on `led_out`
- `busy`  out  1  sequence running
- `done`  out  1  one-cycle pulse on normal completion

## Operation

- States: IDLE, RUN. Reset → IDLE; all outputs 0; table cleared to 0; internal counter 0.
- Table writes accepted in any state. Written word is visible only at the next entry load; if a write and a load hit the same address on the same edge, the load takes the old value.
- IDLE, `start`=1, `stop`=0: latch `len` (clamped to DEPTH if larger), `period`, `loop`. If latched len = 0: stay IDLE, pulse `done` next cycle, `led_out` unchanged. Else → RUN, `led_out`←table[0], `step_idx`←0, `step_tick`=1, counter←0.
- RUN: counter increments each cycle. When counter == latched period: counter←0; if `step_idx` < len−1 load next entry (`step_tick`=1); else if loop, load entry 0 (`step_tick`=1); else → IDLE, `done`=1, `led_out` holds last entry.
- `stop`=1 in RUN: → IDLE, counter←0, `led_out` and `step_idx` hold current values, no `done`. `stop` wins over `start` in the same cycle; `stop` in IDLE has no effect.
- `start` while RUN is ignored; `len`/`period`/`loop` changes during RUN have no effect until next start.
- Counter arithmetic unsigned PW bits; period = 0 gives one-cycle steps; period = 2^PW−1 must work without overflow.

## Timing

- All outputs registered. `start` sampled at edge t → `busy`, `led_out`=entry 0, `step_tick` valid in cycle t+1.
- Each entry held exactly period+1 cycles.
- Non-loop pass: `busy` falls and `done` pulses in cycle t+1+len·(period+1); a new `start` is accepted in that same cycle.
- `stop` sampled at edge s → `busy`=0 in cycle s+1.
- `rst` mid-run: next cycle matches reset state exactly, table included.

## Structure

- Shared package/include: state encoding localparams (ST_IDLE, ST_RUN), default WIDTH/DEPTH/PW.
- One sub-module: `gpio_step_timer` (PW-bit counter with clear, terminal-count output at count == period). Table, FSM and output registers stay in the top.

## Test plan

- Write 0x01,0x02,0x04,0x08; len=4, period=3, loop=0; start → `led_out` 01,02,04,08 each 4 cycles, 4 `step_tick` pulses, `done` exactly at t+17, `led_out` stays 08.
- Same table, loop=1, period=0 → sequence repeats 01,02,04,08,01… every cycle; no `done`; `stop` mid-pass freezes current value, `busy`=0 next cycle, no `done`.
- len=0 start → `done` pulse next cycle, `busy` never high; len=12 with DEPTH=8 → plays 8 entries then `done`.
- Write addr 1 = 0xAA while entry 0 shown → step 1 shows 0xAA; write addr 1 on the same edge entry 1 loads → old value shown.
- `start`+`stop` same cycle in IDLE → stays IDLE; `start` during RUN ignored; new `start` in the `done` cycle accepted.
- `rst` asserted mid-run → all outputs 0, table reads back 0 on next run.
